// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t  fetch sequencer states
//   fetch_entry_t  one prefetch queue entry {pc, instr, fault}
//   INSTR_NOP      word substituted for a faulting fetch (addi x0, x0, 0)
// FETCH_XLEN sets the PC width carried in queue entries; the fetch unit's
// XLEN parameter defaults to it and the two must agree (32 or 64).
package cpu_fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FLUSH,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: synchronous prefetch FIFO of fetch_entry_t.
//   clk, reset     clock, asynchronous active-high reset
//   flush          clears the queue; wins over enq and deq
//   enq, enq_data  write one entry at the tail
//   deq            drop the head entry (caller guarantees non-empty)
//   head           head entry, all zero when empty
//   count          number of valid entries (0..DEPTH)
//   full, empty    occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq,
  input  fetch_entry_t             enq_data,
  input  logic                     deq,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cpu_insfetch.sv
// cpu_insfetch: instruction fetch unit feeding decode.
// Issues one word-aligned read at a time, buffers returned words in a
// DEPTH-entry prefetch queue and presents them with a valid/ready handshake.
// Redirects flush the queue and discard the in-flight response.
//   clk, reset                 clock, asynchronous active-high reset
//   redirect_valid/_pc         restart fetch at redirect_pc (bits [1:0] ignored)
//   mem_req_valid/_ready/_addr read request to instruction memory
//   mem_resp_valid/_data/_err  in-order read response, err = access fault
//   instr_valid/_ready         decode handshake
//   instr, instr_pc, instr_fault  head instruction and its attributes
// Build option FETCH_BYPASS_EN: a response arriving at an empty queue is
// presented to decode in the same cycle instead of one cycle later.
module cpu_insfetch
  import cpu_fetch_pkg::*;
#(
  parameter int               XLEN         = FETCH_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               DEPTH        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  input  logic             mem_resp_err,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic             instr_fault
);

  fetch_state_t            state, state_nxt;
  logic [XLEN-1:0]         fetch_pc, fetch_pc_nxt;
  logic                    run;
  logic                    req_hs, resp_take, bypass, enq, deq;
  fetch_entry_t            resp_entry, head, out_entry;
  logic [$clog2(DEPTH):0]  q_count;
  logic                    q_full, q_empty;

  // run holds off requests until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_VECTOR;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      run      <= 1'b1;
    end
  end

  assign mem_req_valid = run && (state == S_REQ) && !q_full;
  assign mem_req_addr  = fetch_pc;
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign resp_take     = (state == S_WAIT) && mem_resp_valid && !redirect_valid;

  always_comb begin
    resp_entry.pc    = fetch_pc;
    resp_entry.instr = mem_resp_err ? INSTR_NOP : mem_resp_data;
    resp_entry.fault = mem_resp_err;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_REQ: begin
        if (redirect_valid) state_nxt = req_hs ? S_FLUSH : S_REQ;
        else if (req_hs)    state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)      state_nxt = mem_resp_valid ? S_REQ : S_FLUSH;
        else if (mem_resp_valid) state_nxt = mem_resp_err ? S_HALT : S_REQ;
      end
      // A redirect here changes only fetch_pc; the old response is still owed.
      S_FLUSH: begin
        if (mem_resp_valid) state_nxt = S_REQ;
      end
      S_HALT: begin
        if (redirect_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_valid)                   fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    else if (resp_take && !mem_resp_err)  fetch_pc_nxt = fetch_pc + XLEN'(4);
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_take && q_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode this cycle never occupies the queue.
  assign enq = resp_take && !(bypass && instr_ready);
  assign deq = !q_empty && instr_ready && !redirect_valid;

  cpu_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .enq      (enq),
    .enq_data (resp_entry),
    .deq      (deq),
    .head     (head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign out_entry   = bypass ? resp_entry : head;
  assign instr_valid = (q_count != '0) || bypass;
  assign instr       = out_entry.instr;
  assign instr_pc    = out_entry.pc;
  assign instr_fault = out_entry.fault;

endmodule

// File: doc/cpu_insfetch.md
Name: cpu_insfetch

Overview:
- Instruction fetch unit. It is the producer side of the 32-bit instruction word that the decode stage consumes.
- Issues word-aligned read requests to the instruction memory port and buffers the returned words in a small prefetch queue.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Handles pipeline redirects (branch, jump, trap) by flushing the queue and discarding in-flight data.

Parameters:
- XLEN, 32, address/PC width (32 or 64).
- RESET_VECTOR, {XLEN{1'b0}}, first fetch address after reset.
- DEPTH, 2, prefetch queue entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  single-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored (treated as 0).
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned read address.
- mem_resp_valid  in  1  read data returned (one response per accepted request, in order).
- mem_resp_data  in  32  instruction word.
- mem_resp_err  in  1  access fault for this response.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  32  instruction word to decode.
- instr_pc  out  XLEN  PC of instr.
- instr_fault  out  1  instr carries an access fault.

Behaviour:
- Reset: asynchronous, active-high; clock is clk.
  - Reset values: state=S_REQ, fetch_pc=RESET_VECTOR, queue empty.
  - Output reset values: mem_req_valid=0, mem_req_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
  - mem_req_valid rises no earlier than the first clock edge after reset deasserts.
  - Reset asserted mid-transaction abandons everything. A late response arriving after reset must be discarded; S_FLUSH is entered only via redirect, so the memory side must also be reset by the same signal.
- Single outstanding request. Transaction = mem_req_valid & mem_req_ready; response may arrive 1+ cycles later, never in the same cycle.
- States:
  - S_REQ: mem_req_valid=1 only when count<DEPTH, with mem_req_addr=fetch_pc. On handshake -> S_WAIT.
  - S_WAIT: await mem_resp_valid.
    - err=0: enqueue {fetch_pc, data, 0}, fetch_pc += 4 (wraps modulo 2^XLEN), -> S_REQ.
    - err=1: enqueue {fetch_pc, 32'h00000013, 1}, -> S_HALT.
  - S_FLUSH: await the stale response, drop it without enqueueing, -> S_REQ.
  - S_HALT: no requests. Leave only on redirect.
- Redirect: highest priority in every state. Same cycle:
  - queue cleared;
  - instr dequeue ignored;
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
- Next state on redirect:
  - S_WAIT with no response this cycle -> S_FLUSH.
  - S_WAIT with a response this cycle -> drop it, -> S_REQ.
  - S_REQ with handshake this cycle -> S_FLUSH.
  - S_REQ without handshake, S_FLUSH, or S_HALT -> S_REQ. In S_FLUSH a response may still be pending; stay S_FLUSH if no response this cycle.
- Queue:
  - instr/instr_pc/instr_fault driven from head entry; all zero when empty.
  - instr_valid = (count != 0).
  - Dequeue on instr_valid & instr_ready.
  - Simultaneous enqueue and dequeue when full is impossible, because a request is never issued at count==DEPTH.
  - Simultaneous enqueue and dequeue otherwise: count unchanged.
- Latency: response to instr_valid is 1 cycle (registered queue). Back-to-back fetch throughput is 1 instruction per 2 cycles at minimum memory latency.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and a non-dropped response arrives, instr_valid=1 combinationally that cycle with the response fields.
  - If instr_ready=1 as well, the response is not written to the queue; otherwise it is enqueued normally.
  - Redirect in the same cycle suppresses the bypass.
- Undefined: responses always pass through the queue (1-cycle latency).

Decomposition:
- Package cpu_fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_FLUSH, S_HALT};
  - fetch_entry_t packed struct {pc, instr, fault}, parameterised by XLEN via localparam width;
  - constant INSTR_NOP = 32'h00000013.
- One sub-module: cpu_fetch_queue.
  - Synchronous FIFO of fetch_entry_t, DEPTH entries.
  - Ports: enq, deq, flush, count, full, empty.
  - Flush has priority over enq and deq.

Test Plan:
- Reset release, memory ready always, 1-cycle response with data 0x00500093 at RESET_VECTOR=0x100 -> first mem_req_addr=0x100; instr_valid with instr=0x00500093, instr_pc=0x100, fault=0; next request 0x104.
- instr_ready held 0 with DEPTH=2 -> exactly 2 requests issued, mem_req_valid stays 0. Raise instr_ready -> entries at pc 0x100 and 0x104 drain in order, fetching resumes at 0x108.
- Redirect to 0x203 while in S_WAIT (response 3 cycles later) -> stale response dropped, queue empty, next request addr 0x200, no instr_valid for the stale word.
- mem_resp_err=1 at 0x10C -> instr=0x00000013, instr_fault=1, instr_pc=0x10C, no further requests. Then redirect to 0x400 -> request at 0x400.
- fetch_pc=0xFFFFFFFC (XLEN=32) -> fetches 0xFFFFFFFC then wraps to 0x00000000.
- With FETCH_BYPASS_EN, empty queue, instr_ready=1 -> instr_valid in the same cycle as mem_resp_valid, count stays 0; without it, instr_valid is one cycle later.
